// File: rtl/imm_encoder_pkg.sv
// Shared constants and types for the immediate encoder.
// ImmSrc codes match the datapath extender.
package imm_encoder_pkg;

  localparam int DW = 32;
  localparam int FW = 24;

  localparam logic [1:0] IMM_SRC_8  = 2'b00;
  localparam logic [1:0] IMM_SRC_12 = 2'b01;
  localparam logic [1:0] IMM_SRC_BR = 2'b10;
  localparam logic [1:0] KIND_AUTO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [FW-1:0] cand_field(
    input logic [DW-1:0] v,
    input logic [1:0]    src
  );
    logic [FW-1:0] f;
    f = '0;
    unique case (src)
      IMM_SRC_8:  f = {16'b0, v[7:0]};
      IMM_SRC_12: f = {12'b0, v[11:0]};
      IMM_SRC_BR: f = v[25:2];
      default:    f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle for the immediate encoder.
// master = requester, slave = encoder.
interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_value;
  logic [1:0]    req_kind;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [FW-1:0] rsp_field;
  logic [1:0]    rsp_imm_src;
  logic          rsp_ok;

  modport master (
    output req_valid,
    output req_value,
    output req_kind,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_field,
    input  rsp_imm_src,
    input  rsp_ok
  );

  modport slave (
    input  req_valid,
    input  req_value,
    input  req_kind,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_field,
    output rsp_imm_src,
    output rsp_ok
  );

endinterface

// File: rtl/imm_expand.sv
// Combinational field + ImmSrc re-expansion.
// Bit-for-bit copy of the datapath extender.
module imm_expand
  import imm_encoder_pkg::*;
(
  input  logic [FW-1:0] f,
  input  logic [1:0]    src,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    unique case (src)
      IMM_SRC_8:  y = {24'b0, f[7:0]};
      IMM_SRC_12: y = {20'b0, f[11:0]};
      IMM_SRC_BR: y = {6'b0, f[23:0], 2'b00};
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: finds field/ImmSrc that re-expand to a constant.
// Each candidate is proven by round-trip through imm_expand.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  imm_encoder_if.slave  bus
);

  state_t        state_q, state_d;
  logic [DW-1:0] value_q, value_d;
  logic [1:0]    kind_q, kind_d;
  logic [1:0]    cand_q, cand_d;
  logic [FW-1:0] field_q, field_d;
  logic [1:0]    src_q, src_d;
  logic          ok_q, ok_d;

  logic [FW-1:0] try_field;
  logic [DW-1:0] try_exp;
  logic          try_hit;

  assign try_field = cand_field(value_q, cand_q);

  imm_expand u_expand (
    .f   (try_field),
    .src (cand_q),
    .y   (try_exp)
  );

  assign try_hit = (try_exp == value_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      value_q <= '0;
      kind_q  <= '0;
      cand_q  <= '0;
      field_q <= '0;
      src_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      kind_q  <= kind_d;
      cand_q  <= cand_d;
      field_q <= field_d;
      src_q   <= src_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    kind_d  = kind_q;
    cand_d  = cand_q;
    field_d = field_q;
    src_d   = src_q;
    ok_d    = ok_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = TRY;
          value_d = bus.req_value;
          kind_d  = bus.req_kind;
          cand_d  = (bus.req_kind == KIND_AUTO)
                  ? IMM_SRC_8 : bus.req_kind;
        end
      end
      TRY: begin
        if (try_hit) begin
          state_d = RESP;
          ok_d    = 1'b1;
          field_d = try_field;
          src_d   = cand_q;
        end else if (kind_q == KIND_AUTO &&
                     cand_q != IMM_SRC_BR) begin
          cand_d  = cand_q + 2'd1;
        end else begin
          state_d = RESP;
          ok_d    = 1'b0;
          field_d = '0;
          src_d   = cand_q;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_field   = field_q;
  assign bus.rsp_imm_src = src_q;
  assign bus.rsp_ok      = ok_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder.
// Range-based encodability model plus literal vectors.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [23:0] exp_field;
  logic [1:0]  exp_src;
  logic        exp_ok;
  int          exp_lat;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  function automatic bit fits(input logic [31:0] v, input int c);
    case (c)
      0: return v < 32'd256;
      1: return v < 32'd4096;
      2: return (v % 4 == 0) && (v < 32'h0400_0000);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic [31:0] v, input logic [1:0] k);
    int first, last;
    first = (k == 2'b11) ? 0 : int'(k);
    last  = (k == 2'b11) ? 2 : int'(k);
    exp_ok = 1'b0;
    exp_field = '0;
    exp_src = 2'(last);
    exp_lat = last - first + 1;
    for (int c = first; c <= last; c++) begin
      if (fits(v, c)) begin
        exp_ok = 1'b1;
        exp_src = 2'(c);
        exp_field = (c == 2) ? 24'(v >> 2) : 24'(v);
        exp_lat = c - first + 1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid) begin
      chk("mon_field", 32'(bus.rsp_field), 32'(exp_field));
      chk("mon_src", 32'(bus.rsp_imm_src), 32'(exp_src));
      chk("mon_ok", 32'(bus.rsp_ok), 32'(exp_ok));
      chk("mon_req_ready", 32'(bus.req_ready), 32'd0);
    end
  end

  task automatic start(input logic [31:0] v, input logic [1:0] k);
    int n;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    model(v, k);
    bus.req_valid = 1'b1;
    bus.req_value = v;
    bus.req_kind  = k;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    chk("latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run(input logic [31:0] v, input logic [1:0] k,
                     input logic [23:0] lf, input logic [1:0] ls,
                     input logic lo, input int ll);
    int n;
    start(v, k);
    wait_rsp(n);
    chk("lit_field", 32'(bus.rsp_field), 32'(lf));
    chk("lit_src", 32'(bus.rsp_imm_src), 32'(ls));
    chk("lit_ok", 32'(bus.rsp_ok), 32'(lo));
    chk("lit_latency", 32'(n), 32'(ll));
    handshake();
  endtask

  task automatic run_model(input logic [31:0] v, input logic [1:0] k);
    int n;
    start(v, k);
    wait_rsp(n);
    handshake();
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_value = '0;
    bus.req_kind  = '0;
    bus.rsp_ready = 1'b0;
    exp_field = '0;
    exp_src = '0;
    exp_ok = 1'b0;
    exp_lat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ok", 32'(bus.rsp_ok), 32'd0);
    chk("rst_field", 32'(bus.rsp_field), 32'd0);
    chk("rst_src", 32'(bus.rsp_imm_src), 32'd0);

    run(32'h0000_00A5, 2'b00, 24'h0000A5, 2'b00, 1'b1, 1);
    run(32'h0000_0100, 2'b00, 24'h000000, 2'b00, 1'b0, 1);
    run(32'h0000_0ABC, 2'b11, 24'h000ABC, 2'b01, 1'b1, 2);
    run(32'h0000_1000, 2'b11, 24'h000400, 2'b10, 1'b1, 3);
    run(32'h0000_1001, 2'b11, 24'h000000, 2'b10, 1'b0, 3);
    run(32'h0000_0000, 2'b11, 24'h000000, 2'b00, 1'b1, 1);
    run(32'h0000_00FF, 2'b11, 24'h0000FF, 2'b00, 1'b1, 1);
    run(32'h0000_0100, 2'b11, 24'h000100, 2'b01, 1'b1, 2);
    run(32'h0000_0FFF, 2'b01, 24'h000FFF, 2'b01, 1'b1, 1);
    run(32'h0000_1000, 2'b01, 24'h000000, 2'b01, 1'b0, 1);
    run(32'h03FF_FFFC, 2'b10, 24'hFFFFFF, 2'b10, 1'b1, 1);
    run(32'h03FF_FFFC, 2'b11, 24'hFFFFFF, 2'b10, 1'b1, 3);
    run(32'h0000_0ABE, 2'b10, 24'h000000, 2'b10, 1'b0, 1);

    // Backpressure: a new request waits behind the held response
    start(32'h0000_0012, 2'b00);
    wait_rsp(n);
    bus.req_valid = 1'b1;
    bus.req_value = 32'h0000_0345;
    bus.req_kind  = 2'b11;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_field", 32'(bus.rsp_field), 32'h12);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(bus.req_ready), 32'd1);
    model(32'h0000_0345, 2'b11);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_taken", 32'(bus.req_ready), 32'd0);
    wait_rsp(n);
    chk("bp_new_field", 32'(bus.rsp_field), 32'h345);
    chk("bp_new_src", 32'(bus.rsp_imm_src), 32'd1);
    handshake();

    // Reset while searching drops the request
    start(32'h0000_1001, 2'b11);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_ok", 32'(bus.rsp_ok), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_quiet", 32'(bus.rsp_valid), 32'd0);
    end
    run(32'h0400_0000, 2'b10, 24'h000000, 2'b10, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] v;
      case (i % 4)
        0: v = $urandom_range(0, 511);
        1: v = $urandom_range(0, 8191);
        2: v = $urandom & 32'h07FF_FFFC;
        default: v = $urandom;
      endcase
      run_model(v, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
